// File: rtl/control_moore.sv
// Moore detector: z is high while the last two sampled bits of w are equal.
// The state type lives in a package so the encoding can be referenced by name.
package controlMoorePkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ONE0 = 3'd1,
        ONE1 = 3'd2,
        RUN0 = 3'd3,
        RUN1 = 3'd4
    } stateT;
endpackage

module control_moore
    import controlMoorePkg::*;
(
    input  logic w,
    input  logic clk,
    input  logic reset,
    output logic z
);

    stateT state;
    stateT nextState;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // An unknown w or an unused code falls back to IDLE so the FSM always recovers.
    always_comb begin
        nextState = IDLE;
        z         = 1'b0;
        case (state)
            IDLE, ONE1, RUN1: begin
                case (w)
                    1'b0:    nextState = ONE0;
                    1'b1:    nextState = (state == IDLE) ? ONE1 : RUN1;
                    default: nextState = IDLE;
                endcase
                z = (state == RUN1);
            end
            ONE0, RUN0: begin
                case (w)
                    1'b0:    nextState = RUN0;
                    1'b1:    nextState = ONE1;
                    default: nextState = IDLE;
                endcase
                z = (state == RUN0);
            end
            default: begin
                nextState = IDLE;
                z         = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_moore.sv
// Directed bench for control_moore: reset, sequence detection, async reset
// mid-run and recovery from an unused state encoding.
module tb_control_moore;
    import controlMoorePkg::*;

    logic w;
    logic clk;
    logic reset;
    logic z;

    int vectors;
    int miscompares;

    control_moore dut (
        .w     (w),
        .clk   (clk),
        .reset (reset),
        .z     (z)
    );

    // Free-running clock, period 10, starts at 0.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkZ(input string tag, input logic expZ);
        vectors++;
        assert (z === expZ) else begin
            miscompares++;
            $error("FAIL %s: z=%b expected %b", tag, z, expZ);
        end
    endtask

    task automatic checkState(input string tag, input stateT expState);
        vectors++;
        assert (dut.state === expState) else begin
            miscompares++;
            $error("FAIL %s: state=%0d expected %0d", tag, dut.state, expState);
        end
    endtask

    // Called at a falling edge: drive w, sample z just after the rising edge,
    // then return at the next falling edge.
    task automatic step(input string tag, input logic wVal, input logic expZ);
        w = wVal;
        @(posedge clk);
        #1;
        checkZ(tag, expZ);
        @(negedge clk);
    endtask

    // Called at a falling edge: reset held low across one rising edge.
    task automatic pulseReset(input string tag);
        reset = 1'b0;
        #1;
        checkZ({tag, "_async"}, 1'b0);
        @(posedge clk);
        #1;
        checkZ({tag, "_held"}, 1'b0);
        checkState({tag, "_state"}, IDLE);
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic mainW[12] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 1};
    logic mainZ[12] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0};

    initial begin
        vectors     = 0;
        miscompares = 0;
        w           = 1'b0;
        reset       = 1'b0;

        // Reset held for two cycles while w toggles.
        #1;
        checkZ("reset_t0", 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            w = ~w;
            @(posedge clk);
            #1;
            checkZ("reset_hold", 1'b0);
            checkState("reset_hold_state", IDLE);
        end
        @(negedge clk);
        reset = 1'b1;

        // Main sequence.
        for (int i = 0; i < 12; i++) begin
            step($sformatf("main_%0d", i), mainW[i], mainZ[i]);
        end

        // Long run of 1s, then a single 0.
        pulseReset("rst_long");
        step("long_0", 1'b1, 1'b0);
        for (int i = 1; i < 6; i++) begin
            step($sformatf("long_%0d", i), 1'b1, 1'b1);
        end
        checkState("long_state", RUN1);
        step("long_break", 1'b0, 1'b0);

        // Alternating input never detects.
        pulseReset("rst_alt");
        for (int i = 0; i < 8; i++) begin
            step($sformatf("alt_%0d", i), logic'(i % 2), 1'b0);
        end

        // Asynchronous reset during a run of 1s.
        pulseReset("rst_run");
        step("run_0", 1'b1, 1'b0);
        w = 1'b1;
        @(posedge clk);
        #1;
        checkZ("run_1", 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkZ("run_async_drop", 1'b0);
        checkState("run_async_state", IDLE);
        @(negedge clk);
        reset = 1'b1;
        step("after_rst_0", 1'b1, 1'b0);
        step("after_rst_1", 1'b1, 1'b1);

        // Unused encoding recovers to IDLE on the next edge.
        force dut.state = stateT'(3'd5);
        #1;
        checkZ("illegal_forced", 1'b0);
        release dut.state;
        w = 1'b1;
        @(posedge clk);
        #1;
        checkState("illegal_recover", IDLE);
        checkZ("illegal_recover_z", 1'b0);
        @(negedge clk);
        step("illegal_then_0", 1'b1, 1'b0);
        step("illegal_then_1", 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
